// File: rtl/muldiv_pkg.sv
// Shared types and helpers for the execute-stage multiply/divide scheduler.
package muldiv_pkg;

    typedef enum logic [2:0] {
        MD_NONE  = 3'd0,
        MD_MULT  = 3'd1,
        MD_MULTU = 3'd2,
        MD_DIV   = 3'd3,
        MD_DIVU  = 3'd4
    } muldiv_op_t;

    typedef logic [1:0] muldiv_state_t;

    localparam muldiv_state_t ST_IDLE = 2'd0;
    localparam muldiv_state_t ST_MUL  = 2'd1;
    localparam muldiv_state_t ST_DIV  = 2'd2;
    localparam muldiv_state_t ST_DONE = 2'd3;

    localparam int DIV_STEPS = 32;

    function automatic logic [31:0] cond_neg32(input logic neg, input logic [31:0] v);
        return neg ? (~v + 32'd1) : v;
    endfunction

    function automatic logic [63:0] cond_neg64(input logic neg, input logic [63:0] v);
        return neg ? (~v + 64'd1) : v;
    endfunction

endpackage

// File: rtl/muldiv_div_iter.sv
// Unsigned 32/32 restoring divider, one quotient bit per cycle.
// Handshake: start_i loads operands (ignored while abort_i); done_o is high in the cycle whose edge completes the last step, so {rem,quot} on result_o is valid from the next cycle until the next start_i.
module muldiv_div_iter
    import muldiv_pkg::*;
(
    input  logic        clk,
    input  logic        resetn,
    input  logic        start_i,
    input  logic        abort_i,
    input  logic [31:0] dividend_i,
    input  logic [31:0] divisor_i,
    output logic        done_o,
    output logic [63:0] result_o
);

    localparam int STEP_W = $clog2(DIV_STEPS);
    localparam logic [STEP_W-1:0] LAST_STEP = STEP_W'(DIV_STEPS - 1);

    logic              run_q,  run_d;
    logic [STEP_W-1:0] step_q, step_d;
    logic [31:0]       rem_q,  rem_d;
    logic [31:0]       quo_q,  quo_d;
    logic [31:0]       dvs_q,  dvs_d;
    logic [32:0]       trial;

    // A zero divisor never borrows, so the quotient fills with ones and the dividend shifts into rem.
    always_comb begin
        trial  = {rem_q, quo_q[31]} - {1'b0, dvs_q};
        run_d  = run_q;
        step_d = step_q;
        rem_d  = rem_q;
        quo_d  = quo_q;
        dvs_d  = dvs_q;
        if (abort_i) begin
            run_d = 1'b0;
        end else if (start_i) begin
            run_d  = 1'b1;
            step_d = '0;
            rem_d  = '0;
            quo_d  = dividend_i;
            dvs_d  = divisor_i;
        end else if (run_q) begin
            if (trial[32]) begin
                rem_d = {rem_q[30:0], quo_q[31]};
                quo_d = {quo_q[30:0], 1'b0};
            end else begin
                rem_d = trial[31:0];
                quo_d = {quo_q[30:0], 1'b1};
            end
            step_d = step_q + 1'b1;
            if (step_q == LAST_STEP) begin
                run_d = 1'b0;
            end
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            run_q  <= 1'b0;
            step_q <= '0;
            rem_q  <= '0;
            quo_q  <= '0;
            dvs_q  <= '0;
        end else begin
            run_q  <= run_d;
            step_q <= step_d;
            rem_q  <= rem_d;
            quo_q  <= quo_d;
            dvs_q  <= dvs_d;
        end
    end

    assign done_o   = run_q && (step_q == LAST_STEP) && !abort_i;
    assign result_o = {rem_q, quo_q};

endmodule

// File: rtl/muldiv_ctrl.sv
// Arbitrates the shared mul/div unit between issue lanes, sequences the op,
// stalls execute while busy and holds the sign-corrected {hi,lo} until downstream accepts.
module muldiv_ctrl
    import muldiv_pkg::*;
#(
    parameter int MUL_LAT = 3
) (
    input  logic                  clk,
    input  logic                  resetn,
    input  muldiv_op_t [1:0]      req_op,
    input  logic [1:0][31:0]      rs,
    input  logic [1:0][31:0]      rt,
    input  logic                  d_wait,
    input  logic                  flush,
    output logic                  e_wait,
    output logic                  res_valid,
    output logic                  res_lane,
    output logic [63:0]           hilo,
    output logic                  busy,
    output muldiv_state_t         dbg_state
);

    localparam int CNT_W = (MUL_LAT > 1) ? $clog2(MUL_LAT) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MUL_LAT - 1);

    muldiv_state_t    state_q, state_d;
    logic [CNT_W-1:0] cnt_q,   cnt_d;
    logic             lane_q, is_div_q, sa_q, sb_q;
    logic [31:0]      mag_a_q, mag_b_q;
    logic [63:0]      prod_q;

    logic             req_any, sel_lane, sel_signed, sel_div, sel_sa, sel_sb, accept;
    muldiv_op_t       sel_op;
    logic [31:0]      sel_rs, sel_rt, sel_mag_a, sel_mag_b;
    logic             div_done;
    logic [63:0]      div_result, res_full;

    // Lane 1 has priority; a simultaneous lane 0 request is simply not served.
    always_comb begin
        req_any    = (req_op[1] != MD_NONE) || (req_op[0] != MD_NONE);
        sel_lane   = (req_op[1] != MD_NONE);
        sel_op     = req_op[sel_lane];
        sel_rs     = rs[sel_lane];
        sel_rt     = rt[sel_lane];
        sel_signed = (sel_op == MD_MULT) || (sel_op == MD_DIV);
        sel_div    = (sel_op == MD_DIV) || (sel_op == MD_DIVU);
        sel_sa     = sel_signed && sel_rs[31];
        sel_sb     = sel_signed && sel_rt[31];
        sel_mag_a  = cond_neg32(sel_sa, sel_rs);
        sel_mag_b  = cond_neg32(sel_sb, sel_rt);
        accept     = (state_q == ST_IDLE) && req_any && !flush;
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    state_d = sel_div ? ST_DIV : ST_MUL;
                    cnt_d   = '0;
                end
            end
            ST_MUL: begin
                if (cnt_q == CNT_LAST) begin
                    state_d = ST_DONE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            ST_DIV: begin
                if (div_done) begin
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                if (!d_wait) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
        if (flush) begin
            state_d = ST_IDLE;
            cnt_d   = '0;
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q  <= ST_IDLE;
            cnt_q    <= '0;
            lane_q   <= 1'b0;
            is_div_q <= 1'b0;
            sa_q     <= 1'b0;
            sb_q     <= 1'b0;
            mag_a_q  <= '0;
            mag_b_q  <= '0;
            prod_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            if (accept) begin
                lane_q   <= sel_lane;
                is_div_q <= sel_div;
                sa_q     <= sel_sa;
                sb_q     <= sel_sb;
                mag_a_q  <= sel_mag_a;
                mag_b_q  <= sel_mag_b;
            end
            // Operands are stable throughout MUL, so the product is ready by the first DONE cycle.
            if (state_q == ST_MUL) begin
                prod_q <= {32'b0, mag_a_q} * {32'b0, mag_b_q};
            end
        end
    end

    muldiv_div_iter u_div (
        .clk        (clk),
        .resetn     (resetn),
        .start_i    (accept && sel_div),
        .abort_i    (flush),
        .dividend_i (sel_mag_a),
        .divisor_i  (sel_mag_b),
        .done_o     (div_done),
        .result_o   (div_result)
    );

    // Remainder takes the dividend's sign; quotient and product take the XOR of both signs.
    always_comb begin
        if (is_div_q) begin
            res_full = {cond_neg32(sa_q, div_result[63:32]),
                        cond_neg32(sa_q ^ sb_q, div_result[31:0])};
        end else begin
            res_full = cond_neg64(sa_q ^ sb_q, prod_q);
        end
    end

    assign res_valid = (state_q == ST_DONE);
    assign hilo      = res_valid ? res_full : 64'd0;
    assign busy      = (state_q == ST_MUL) || (state_q == ST_DIV);
    assign e_wait    = accept || busy;
    assign res_lane  = lane_q;
    assign dbg_state = state_q;

endmodule

// File: tb/tb_muldiv_ctrl.sv
// Directed bench for muldiv_ctrl: lane arbitration, signed/unsigned results, latency, stall hold, flush and reset.
module tb_muldiv_ctrl;
    import muldiv_pkg::*;

    localparam int MUL_LAT = 3;
    localparam int MUL_RES = MUL_LAT + 1;
    localparam int DIV_RES = DIV_STEPS + 1;

    logic             clk;
    logic             resetn;
    muldiv_op_t [1:0] req_op;
    logic [1:0][31:0] rs;
    logic [1:0][31:0] rt;
    logic             d_wait;
    logic             flush;
    logic             e_wait;
    logic             res_valid;
    logic             res_lane;
    logic [63:0]      hilo;
    logic             busy;
    muldiv_state_t    dbg_state;

    int   n_pass  = 0;
    int   n_total = 0;
    logic ok;

    muldiv_ctrl #(.MUL_LAT(MUL_LAT)) dut (
        .clk       (clk),
        .resetn    (resetn),
        .req_op    (req_op),
        .rs        (rs),
        .rt        (rt),
        .d_wait    (d_wait),
        .flush     (flush),
        .e_wait    (e_wait),
        .res_valid (res_valid),
        .res_lane  (res_lane),
        .hilo      (hilo),
        .busy      (busy),
        .dbg_state (dbg_state)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: observed no finish, expected finish before time limit");
        $fatal(1, "watchdog expired");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_bit(input string tag, input logic obs, input logic exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    endtask

    task automatic chk_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    task automatic clear_req();
        req_op[0] = MD_NONE;
        req_op[1] = MD_NONE;
        rs        = '0;
        rt        = '0;
    endtask

    // Issues in the current cycle T, then checks busy/e_wait through T+lat-1 and the result at T+lat.
    // Leaves the DUT in its first DONE cycle.
    task automatic do_op(input logic lane, input muldiv_op_t op, input logic [31:0] a,
                         input logic [31:0] b, input int lat, input logic [63:0] exp,
                         input string tag);
        logic win_ok;
        req_op[lane] = op;
        rs[lane]     = a;
        rt[lane]     = b;
        #1;
        chk_bit({tag, "_ewait_accept"}, e_wait, 1'b1);
        tick();
        clear_req();
        win_ok = 1'b1;
        for (int i = 1; i < lat; i++) begin
            if (busy !== 1'b1 || res_valid !== 1'b0 || e_wait !== 1'b1) win_ok = 1'b0;
            tick();
        end
        chk_bit({tag, "_busy_window"}, win_ok, 1'b1);
        chk_bit({tag, "_res_valid"}, res_valid, 1'b1);
        chk_bit({tag, "_res_lane"}, res_lane, lane);
        chk_val({tag, "_hilo"}, hilo, exp);
        chk_bit({tag, "_ewait_done"}, e_wait, 1'b0);
        chk_bit({tag, "_busy_done"}, busy, 1'b0);
    endtask

    initial begin
        resetn = 1'b0;
        d_wait = 1'b0;
        flush  = 1'b0;
        clear_req();
        repeat (2) @(posedge clk);
        #1;
        chk_bit("rst_res_valid", res_valid, 1'b0);
        chk_val("rst_hilo", hilo, 64'd0);
        chk_bit("rst_busy", busy, 1'b0);
        chk_bit("rst_e_wait", e_wait, 1'b0);
        chk_bit("rst_res_lane", res_lane, 1'b0);
        chk_val("rst_state", 64'(dbg_state), 64'(ST_IDLE));
        resetn = 1'b1;
        tick();

        // Flush takes priority over a request sitting in IDLE.
        req_op[0] = MD_MULT;
        rs[0]     = 32'd3;
        rt[0]     = 32'd4;
        flush     = 1'b1;
        #1;
        chk_bit("flush_blocks_ewait", e_wait, 1'b0);
        tick();
        flush = 1'b0;
        clear_req();
        chk_bit("flush_blocks_accept", busy, 1'b0);

        do_op(1'b0, MD_MULT, 32'hFFFF_FFFD, 32'd5, MUL_RES, 64'hFFFF_FFFF_FFFF_FFF1, "mult_l0");
        tick();
        chk_val("mult_l0_idle", 64'(dbg_state), 64'(ST_IDLE));
        chk_val("mult_l0_hilo_cleared", hilo, 64'd0);

        do_op(1'b1, MD_DIVU, 32'd100, 32'd7, DIV_RES, 64'h0000_0002_0000_000E, "divu_l1");
        tick();
        do_op(1'b1, MD_DIV, 32'hFFFF_FF9C, 32'd7, DIV_RES, 64'hFFFF_FFFE_FFFF_FFF2, "div_neg");
        tick();
        do_op(1'b0, MD_DIV, 32'h1234_5678, 32'd0, DIV_RES, 64'h1234_5678_FFFF_FFFF, "div_zero");
        tick();
        do_op(1'b0, MD_DIV, 32'h8000_0000, 32'hFFFF_FFFF, DIV_RES, 64'h0000_0000_8000_0000, "div_ovf");
        tick();
        do_op(1'b0, MD_MULT, 32'd7, 32'hFFFF_FFFA, MUL_RES, 64'hFFFF_FFFF_FFFF_FFD6, "mult_mix");
        tick();

        // Downstream stall: result must hold, and a request seen in DONE must not restart.
        d_wait = 1'b1;
        do_op(1'b0, MD_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, MUL_RES, 64'hFFFF_FFFE_0000_0001, "multu_hold");
        req_op[0] = MD_MULTU;
        rs[0]     = 32'd5;
        rt[0]     = 32'd5;
        ok = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick();
            if (res_valid !== 1'b1 || hilo !== 64'hFFFF_FFFE_0000_0001 || e_wait !== 1'b0 || busy !== 1'b0)
                ok = 1'b0;
        end
        chk_bit("hold_stable", ok, 1'b1);
        d_wait = 1'b0;
        tick();
        clear_req();
        chk_val("hold_release_idle", 64'(dbg_state), 64'(ST_IDLE));
        chk_bit("hold_release_valid", res_valid, 1'b0);
        tick();
        chk_bit("hold_no_reexec", busy, 1'b0);

        // Both lanes request: lane 1 served, lane 0 dropped.
        req_op[0] = MD_DIV;
        rs[0]     = 32'd10;
        rt[0]     = 32'd2;
        do_op(1'b1, MD_MULTU, 32'd2, 32'd3, MUL_RES, 64'd6, "both_lanes");
        ok = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            if (busy !== 1'b0 || res_valid !== 1'b0) ok = 1'b0;
        end
        chk_bit("lane0_dropped", ok, 1'b1);

        // Flush during divide step 10.
        req_op[0] = MD_DIVU;
        rs[0]     = 32'd1000;
        rt[0]     = 32'd33;
        #1;
        tick();
        clear_req();
        repeat (9) tick();
        chk_bit("flush_pre_busy", busy, 1'b1);
        flush = 1'b1;
        tick();
        flush = 1'b0;
        chk_val("flush_div_idle", 64'(dbg_state), 64'(ST_IDLE));
        chk_bit("flush_div_valid", res_valid, 1'b0);
        ok = 1'b1;
        for (int i = 0; i < 30; i++) begin
            tick();
            if (res_valid !== 1'b0 || busy !== 1'b0) ok = 1'b0;
        end
        chk_bit("flush_no_result", ok, 1'b1);
        do_op(1'b0, MD_DIVU, 32'd1000, 32'd33, DIV_RES, 64'h0000_000A_0000_001E, "divu_after_flush");
        tick();

        // Asynchronous reset in the middle of a lane 1 multiply.
        req_op[1] = MD_MULT;
        rs[1]     = 32'd9;
        rt[1]     = 32'd9;
        #1;
        tick();
        clear_req();
        tick();
        chk_bit("pre_reset_busy", busy, 1'b1);
        #2;
        resetn = 1'b0;
        #1;
        chk_bit("midrst_busy", busy, 1'b0);
        chk_bit("midrst_res_valid", res_valid, 1'b0);
        chk_val("midrst_hilo", hilo, 64'd0);
        chk_bit("midrst_res_lane", res_lane, 1'b0);
        chk_bit("midrst_e_wait", e_wait, 1'b0);
        chk_val("midrst_state", 64'(dbg_state), 64'(ST_IDLE));
        tick();
        resetn = 1'b1;
        ok = 1'b1;
        for (int i = 0; i < 6; i++) begin
            tick();
            if (res_valid !== 1'b0 || busy !== 1'b0) ok = 1'b0;
        end
        chk_bit("reset_no_partial", ok, 1'b1);
        do_op(1'b1, MD_MULT, 32'h8000_0000, 32'h8000_0000, MUL_RES, 64'h4000_0000_0000_0000, "mult_min");
        tick();

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
